// File: rtl/ni_pkg.sv
// Shared definitions for the network-interface eject path.
// Holds flit geometry, the head codes the eject port accepts, the flit
// payload struct and a helper that classifies a head code.
package ni_pkg;

  localparam int unsigned FLIT_W    = 16;
  localparam int unsigned HEAD_MSB  = 15;
  localparam int unsigned HEAD_LSB  = 13;
  localparam int unsigned HEAD_W    = HEAD_MSB - HEAD_LSB + 1;
  localparam int unsigned PAYLOAD_W = FLIT_W - HEAD_W;

  localparam logic [HEAD_W-1:0] HEAD_PRIO = 3'b001;
  localparam logic [HEAD_W-1:0] HEAD_REG  = 3'b000;

  // Flit as seen on the router link: head code in the top bits.
  typedef struct packed {
    logic [HEAD_W-1:0]    head;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  // Only priority and regular flits are delivered to the core.
  function automatic logic head_is_kept(input logic [HEAD_W-1:0] head);
    return (head == HEAD_PRIO) || (head == HEAD_REG);
  endfunction

endpackage

// File: rtl/ni_sync_fifo.sv
// Synchronous FIFO with zero-latency read of the head entry.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, wr_data      push request and data (ignored when full)
//   rd_en               pop request (ignored when empty)
//   rd_data             head entry, forced to 0 when empty
//   full, empty         decoded from the registered occupancy
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module ni_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              do_wr;
  logic              do_rd;

  assign full  = (occ == OCC_W'(DEPTH));
  assign empty = (occ == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Pointers and occupancy; a simultaneous push and pop leaves occ unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while occupied.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ni_eject_port.sv
// Eject port of a network interface: accepts flits from the router,
// discards flits whose head code is neither priority nor regular, buffers
// the rest in order and presents them to the local core.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_req, in_data           router flit offer
//   in_bussy                  buffer full, router must hold its flit
//   core_valid, core_data     oldest buffered flit
//   core_prio                 head of core_data is the priority code
//   core_ready                core accepts core_data this cycle
//   prio_cnt, reg_cnt         saturating counts of buffered prio/regular flits
//   drop_cnt                  saturating count of discarded flits
// Build option: define NI_EJECT_STATS_EN to implement the three counters;
// otherwise they read as 0 and no counter state exists.
module ni_eject_port
  import ni_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_req,
  input  logic [FLIT_W-1:0] in_data,
  output logic              in_bussy,
  output logic              core_valid,
  output logic [FLIT_W-1:0] core_data,
  output logic              core_prio,
  input  logic              core_ready,
  output logic [CNT_W-1:0]  prio_cnt,
  output logic [CNT_W-1:0]  reg_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic [1:0]  rst_sync;
  logic        rst_n_int;
  flit_t       in_flit;
  flit_t       out_flit;
  logic        fifo_full;
  logic        fifo_empty;
  logic        in_xfer;
  logic        keep;
  logic        wr_en;
  logic [FLIT_W-1:0] rd_data;

  // Reset asserts immediately, releases two clock edges after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign in_flit  = flit_t'(in_data);
  assign in_xfer  = in_req && !in_bussy;
  assign keep     = head_is_kept(in_flit.head);
  assign wr_en    = in_xfer && keep;

  ni_sync_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n_int),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_en   (core_ready),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_bussy   = fifo_full;
  assign core_valid = !fifo_empty;
  assign core_data  = rd_data;
  assign out_flit   = flit_t'(rd_data);
  assign core_prio  = core_valid && (out_flit.head == HEAD_PRIO);

`ifdef NI_EJECT_STATS_EN
  logic inc_prio;
  logic inc_reg;
  logic inc_drop;

  assign inc_prio = wr_en && (in_flit.head == HEAD_PRIO);
  assign inc_reg  = wr_en && (in_flit.head == HEAD_REG);
  assign inc_drop = in_xfer && !keep;

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      prio_cnt <= '0;
      reg_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (inc_prio && (prio_cnt != '1)) prio_cnt <= prio_cnt + CNT_W'(1);
      if (inc_reg  && (reg_cnt  != '1)) reg_cnt  <= reg_cnt  + CNT_W'(1);
      if (inc_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
`else
  assign prio_cnt = '0;
  assign reg_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ni_eject_port.sv
// Self-checking bench for ni_eject_port: a directed vector table, hand
// sequences for full/drop/simultaneous/saturation/reset, and random traffic
// compared against a queue-based reference model.
module tb_ni_eject_port;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef NI_EJECT_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              in_req;
  logic [15:0]       in_data;
  logic              in_bussy;
  logic              core_valid;
  logic [15:0]       core_data;
  logic              core_prio;
  logic              core_ready;
  logic [CNT_W-1:0]  prio_cnt;
  logic [CNT_W-1:0]  reg_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q[$];
  int m_prio = 0;
  int m_reg  = 0;
  int m_drop = 0;

  typedef struct {
    logic        req;
    logic [15:0] data;
    logic        ready;
    logic        exp_bussy;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_prio;
  } vec_t;

  vec_t vecs[5];

  ni_eject_port #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_req     (in_req),
    .in_data    (in_data),
    .in_bussy   (in_bussy),
    .core_valid (core_valid),
    .core_data  (core_data),
    .core_prio  (core_prio),
    .core_ready (core_ready),
    .prio_cnt   (prio_cnt),
    .reg_cnt    (reg_cnt),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_prio_cnt"}, 32'(prio_cnt), STATS_EN ? 32'(m_prio) : 32'd0);
    check({tag, "_reg_cnt"},  32'(reg_cnt),  STATS_EN ? 32'(m_reg)  : 32'd0);
    check({tag, "_drop_cnt"}, 32'(drop_cnt), STATS_EN ? 32'(m_drop) : 32'd0);
  endtask

  // One clock cycle, entered and left at a falling edge. Outputs are compared
  // against the model before the rising edge; the model then applies the
  // transfers that the rules say happen at that edge.
  task automatic cycle(input logic req, input logic [15:0] data, input logic ready);
    logic        in_x;
    logic        out_x;
    logic [15:0] head_flit;
    logic [2:0]  hd;
    in_req     = req;
    in_data    = data;
    core_ready = ready;
    #1;
    head_flit = (q.size() != 0) ? q[0] : 16'h0000;
    hd        = head_flit[15:13];
    check("in_bussy",   32'(in_bussy),   32'(q.size() == DEPTH));
    check("core_valid", 32'(core_valid), 32'(q.size() != 0));
    check("core_data",  32'(core_data),  32'(head_flit));
    check("core_prio",  32'(core_prio),  32'((q.size() != 0) && (hd == 3'b001)));
    in_x  = req && (q.size() < DEPTH);
    out_x = ready && (q.size() != 0);
    @(posedge clk);
    if (out_x) void'(q.pop_front());
    if (in_x) begin
      hd = data[15:13];
      if (hd == 3'b001) begin
        q.push_back(data);
        m_prio = sat_inc(m_prio);
      end else if (hd == 3'b000) begin
        q.push_back(data);
        m_reg = sat_inc(m_reg);
      end else begin
        m_drop = sat_inc(m_drop);
      end
    end
    @(negedge clk);
    #1;
    check_counters("cyc");
    in_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    q.delete();
    m_prio = 0;
    m_reg  = 0;
    m_drop = 0;
    check("rst_in_bussy",   32'(in_bussy),   32'd0);
    check("rst_core_valid", 32'(core_valid), 32'd0);
    check("rst_core_data",  32'(core_data),  32'd0);
    check("rst_core_prio",  32'(core_prio),  32'd0);
    check_counters("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    rst        = 1'b0;
    in_req     = 1'b0;
    in_data    = '0;
    core_ready = 1'b0;

    // Accept-and-order vectors: each flit appears one cycle after transfer.
    vecs[0] = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 16'h2002, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0};
    vecs[2] = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h2002, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};

    do_reset();

    for (int i = 0; i < 5; i++) begin
      in_req     = vecs[i].req;
      in_data    = vecs[i].data;
      core_ready = vecs[i].ready;
      #1;
      check("vec_bussy", 32'(in_bussy),   32'(vecs[i].exp_bussy));
      check("vec_valid", 32'(core_valid), 32'(vecs[i].exp_valid));
      check("vec_data",  32'(core_data),  32'(vecs[i].exp_data));
      check("vec_prio",  32'(core_prio),  32'(vecs[i].exp_prio));
      cycle(vecs[i].req, vecs[i].data, vecs[i].ready);
    end
    check("order_prio_cnt", 32'(prio_cnt), STATS_EN ? 32'd1 : 32'd0);
    check("order_reg_cnt",  32'(reg_cnt),  STATS_EN ? 32'd2 : 32'd0);

    // Full and backpressure.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0010 + 16'(i), 1'b0);
    check("bp_full_bussy", 32'(in_bussy), 32'd1);
    cycle(1'b1, 16'h0015, 1'b0);
    check("bp_held_bussy", 32'(in_bussy), 32'd1);
    cycle(1'b1, 16'h0015, 1'b1);
    check("bp_after_read_bussy", 32'(in_bussy), 32'd0);
    cycle(1'b1, 16'h0015, 1'b0);
    check("bp_refill_bussy", 32'(in_bussy), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 1'b1);
    check("bp_drained_valid", 32'(core_valid), 32'd0);

    // Drop of an unknown head code, then normal delivery.
    do_reset();
    cycle(1'b1, 16'hE123, 1'b0);
    check("drop_no_valid", 32'(core_valid), 32'd0);
    check("drop_cnt_one",  32'(drop_cnt), STATS_EN ? 32'd1 : 32'd0);
    cycle(1'b1, 16'h0044, 1'b0);
    check("drop_next_data", 32'(core_data), 32'h0044);
    cycle(1'b0, 16'h0000, 1'b1);

    // Simultaneous write and read at occupancy 2.
    cycle(1'b1, 16'h0101, 1'b0);
    cycle(1'b1, 16'h2102, 1'b0);
    cycle(1'b1, 16'h0103, 1'b1);
    check("simul_head", 32'(core_data), 32'h2102);
    cycle(1'b0, 16'h0000, 1'b1);
    check("simul_order", 32'(core_data), 32'h0103);
    cycle(1'b0, 16'h0000, 1'b1);
    check("simul_empty", 32'(core_valid), 32'd0);

    // Saturation of reg_cnt, then reset with three flits buffered.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0200 + 16'(i), 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    check("sat_reg_cnt", 32'(reg_cnt), STATS_EN ? 32'd3 : 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h2300 + 16'(i), 1'b0);
    check("pre_rst_valid", 32'(core_valid), 32'd1);
    do_reset();
    check("post_rst_no_stale", 32'(core_valid), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  hd;
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0:       hd = 3'b000;
        1:       hd = 3'b001;
        2:       hd = 3'b111;
        default: hd = 3'($urandom);
      endcase
      d = {hd, 13'($urandom)};
      cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
